// File: rtl/mole_scorer_if.sv
// Signal bundle between the switch/mole front end and the scoring engine.
// The master drives the game level, switches and mole pattern; the slave returns the scoring results.
interface mole_scorer_if #(
    parameter int N_HOLES = 18,
    parameter int SCORE_W = 10,
    parameter int MISS_W  = 8
);
    logic               game_active;
    logic [N_HOLES-1:0] sw;
    logic [N_HOLES-1:0] mole;
    logic [N_HOLES-1:0] hit_mask;
    logic               hit_pulse;
    logic               miss_pulse;
    logic [SCORE_W-1:0] score;
    logic [MISS_W-1:0]  misses;
    logic [1:0]         state;

    modport master (
        output game_active, sw, mole,
        input  hit_mask, hit_pulse, miss_pulse, score, misses, state
    );

    modport slave (
        input  game_active, sw, mole,
        output hit_mask, hit_pulse, miss_pulse, score, misses, state
    );
endinterface

// File: rtl/mole_scorer.sv
// Whack-a-mole hit/miss scorer: scores every switch toggle against the lit holes,
// counts each mole appearance at most once, and keeps saturating score/miss totals.
module mole_scorer #(
    parameter int N_HOLES = 18,
    parameter int SCORE_W = 10,
    parameter int MISS_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    mole_scorer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int PC_W   = $clog2(N_HOLES + 1);
    // Sums are wide enough for a full-board hit even when the counter is narrower than the popcount.
    localparam int SSUM_W = ((SCORE_W > PC_W) ? SCORE_W : PC_W) + 1;
    localparam int MSUM_W = ((MISS_W > PC_W) ? MISS_W : PC_W) + 1;

    logic [1:0]         r_state;
    logic [N_HOLES-1:0] r_sw_q;
    logic [N_HOLES-1:0] r_claimed;
    logic [N_HOLES-1:0] r_hit_mask;
    logic               r_hit_pulse;
    logic               r_miss_pulse;
    logic [SCORE_W-1:0] r_score;
    logic [MISS_W-1:0]  r_misses;

    logic [1:0]         w_state_next;
    logic               w_scoring;
    logic               w_start;
    logic [N_HOLES-1:0] w_edge;
    logic [N_HOLES-1:0] w_hit;
    logic [N_HOLES-1:0] w_miss;
    logic [PC_W-1:0]    w_hit_cnt;
    logic [PC_W-1:0]    w_miss_cnt;
    logic [SSUM_W-1:0]  w_score_sum;
    logic [MSUM_W-1:0]  w_miss_sum;
    logic [SCORE_W-1:0] w_score_next;
    logic [MISS_W-1:0]  w_misses_next;

    function automatic logic [PC_W-1:0] popcount(input logic [N_HOLES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.game_active)  w_state_next = S_RUN;
            S_RUN:   if (!bus.game_active) w_state_next = S_DONE;
            S_DONE:  if (bus.game_active)  w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The cycle game_active falls is already outside the scoring window.
    assign w_scoring = (r_state == S_RUN) && bus.game_active;
    assign w_start   = (r_state != S_RUN) && (w_state_next == S_RUN);

    assign w_edge = bus.sw ^ r_sw_q;
    assign w_hit  = w_edge & bus.mole & ~r_claimed & {N_HOLES{w_scoring}};
    assign w_miss = w_edge & ~bus.mole & {N_HOLES{w_scoring}};

    assign w_hit_cnt  = popcount(w_hit);
    assign w_miss_cnt = popcount(w_miss);

    assign w_score_sum   = SSUM_W'(r_score) + SSUM_W'(w_hit_cnt);
    assign w_miss_sum    = MSUM_W'(r_misses) + MSUM_W'(w_miss_cnt);
    assign w_score_next  = (|w_score_sum[SSUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
    assign w_misses_next = (|w_miss_sum[MSUM_W-1:MISS_W]) ? {MISS_W{1'b1}} : w_miss_sum[MISS_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sw_q       <= '0;
            r_claimed    <= '0;
            r_hit_mask   <= '0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_score      <= '0;
            r_misses     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_sw_q       <= bus.sw;
            r_hit_mask   <= w_hit;
            r_hit_pulse  <= |w_hit;
            r_miss_pulse <= |w_miss;
            if (w_start) begin
                r_claimed <= '0;
                r_score   <= '0;
                r_misses  <= '0;
            end else begin
                // A hole whose mole is down loses its claim, even if it is being hit this cycle.
                r_claimed <= (r_claimed | w_hit) & bus.mole;
                if (w_scoring) begin
                    r_score  <= w_score_next;
                    r_misses <= w_misses_next;
                end
            end
        end
    end

    assign bus.hit_mask   = r_hit_mask;
    assign bus.hit_pulse  = r_hit_pulse;
    assign bus.miss_pulse = r_miss_pulse;
    assign bus.score      = r_score;
    assign bus.misses     = r_misses;
    assign bus.state      = r_state;
endmodule
